imm_encoder_480: RTL and testbench
==================================

Name: imm_encoder_480

Overview:
- Inverse of the immediate extender: takes a 32-bit signed or unsigned immediate, a one-hot format select and a base instruction word.
- Scatters the immediate into the RISC-V instruction bit positions for that format.
- Flags range, alignment and op errors.
- Two-stage valid/ready pipeline. Sits between the test-program assembler/loader and the instruction memory write port.

Parameters:
- DATA_W, 32, instruction and immediate width (fixed at 32; other values unsupported)
- CNT_W, 16, width of the statistics counters (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat
- in_extop  input  6  one-hot format: 100000 ITYPE_SHAMT, 010000 ITYPE, 001000 STYPE, 000100 BTYPE, 000010 UTYPE, 000001 JTYPE
- in_imm  input  32  immediate value (byte offset for B/J; full value for U)
- in_base  input  32  instruction with opcode/rd/rs/funct fields set; immediate bits are don't-care
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_instr  output  32  packed instruction
- out_err  output  2  00 OK, 01 RANGE, 10 ALIGN, 11 OP

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: s1_valid=0, out_valid=0, out_instr=0, out_err=00, counters=0.
- in_ready = !s1_valid || (!out_valid || out_ready).
- Stage 1 (S1) registers in_extop/in_imm/in_base on in_valid && in_ready.
- Stage 2 (S2) registers the packed word and error when S1 is valid and S2 is empty or draining.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 beat/cycle. No bubbles are inserted while out_ready=1.
- Backpressure (out_ready=0 with out_valid=1): out_instr/out_err hold stable. S1 fills, then in_ready deasserts. No loss, no duplication, order preserved.
- Packing rule: bits not owned by the format pass through from base.
  - ITYPE_SHAMT: [24:20]=imm[4:0]
  - ITYPE: [31:20]=imm[11:0]
  - STYPE: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - BTYPE: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - UTYPE: [31:12]=imm[31:12]
  - JTYPE: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Range checks:
  - SHAMT: imm[31:5]==0
  - I/S: imm[31:11] all equal
  - B: imm[31:12] all equal
  - J: imm[31:20] all equal
  - U: no range check
- Alignment checks: B/J require imm[0]==0; U requires imm[11:0]==0.
- OP error: in_extop zero or multi-hot. In that case out_instr=in_base unmodified.
- Error priority: OP > ALIGN > RANGE. On RANGE/ALIGN the truncated packed word is still output.
- rst mid-operation: all in-flight beats are discarded. out_valid=0 on the cycle after rst is sampled high. in_ready=1 once rst is low.

Optional Feature:
- Macro: IMM_ENC_STATS_EN.
- When defined, adds two outputs:
  - cnt_ok [CNT_W]: increments on each out_valid&&out_ready with out_err==00
  - cnt_err [CNT_W]: increments on each handshake with out_err!=00
- Both counters saturate at all-ones and are cleared by rst.
- When undefined, these ports and their logic do not exist. Datapath behaviour is identical either way.

Decomposition:
- Shared package holds:
  - the EXT_CTRL_* one-hot localparams, shared with the extender
  - the ERR_OK/ERR_RANGE/ERR_ALIGN/ERR_OP codes
- One combinational sub-module, imm_pack_480: inputs extop/imm/base, outputs instr/err.
- The top module holds the S1/S2 registers, the handshake and the optional counters.

Test Plan:
- ITYPE, imm=0xFFFFFFFF, base=0x00000013, out_ready=1 -> after 2 cycles out_instr=0xFFF00013, err=00.
- UTYPE, imm=0x12345000, base=0x00000037 -> 0x12345037, err=00. Same with imm=0x12345001 -> err=10.
- BTYPE, imm=0x00000800, base=0x00000063 -> 0x000000E3, err=00. JTYPE imm=0x00000003 -> err=10. SHAMT imm=32 -> err=01. extop=000011 -> out_instr=base, err=11.
- Back-to-back 4 beats with out_ready held low for 3 cycles -> in_ready drops after the 2nd accept; all 4 emerge in order, each held stable while stalled.
- rst asserted one cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat appears, next accepted beat returns after 2 cycles.
- With IMM_ENC_STATS_EN and CNT_W=4: 20 OK beats -> cnt_ok saturates at 15. 3 errored beats -> cnt_err=3.

Source files
------------

// File: rtl/imm_encoder_480_pkg.sv
// Shared encodings for the immediate extender/encoder pair: one-hot format selects,
// error codes, the stage-1 payload and a sign-run helper.
package imm_encoder_480_pkg;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  typedef struct packed {
    logic [5:0]  extop;
    logic [31:0] imm;
    logic [31:0] base;
  } s1_t;

  // True when v[31:lsb] is a pure sign run, i.e. the value fits in lsb+1 signed bits.
  function automatic logic sign_run_ok(input logic [31:0] v, input int lsb);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 31; k++) begin
      if (k >= lsb && v[k] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_480_pack.sv
// Combinational scatter of an immediate into its RISC-V instruction fields, plus error code.
// Zero latency; no handshake of its own.
module imm_pack_480
  import imm_encoder_480_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        extop,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] instr,
  output logic [1:0]        err
);

  logic range_ok;
  logic align_ok;
  logic op_bad;

  always_comb begin
    instr    = base;
    range_ok = 1'b1;
    align_ok = 1'b1;
    op_bad   = 1'b0;
    case (extop)
      EXT_CTRL_ITYPE_SHAMT: begin
        instr[24:20] = imm[4:0];
        range_ok     = (imm[31:5] == 27'd0);
      end
      EXT_CTRL_ITYPE: begin
        instr[31:20] = imm[11:0];
        range_ok     = sign_run_ok(imm, 11);
      end
      EXT_CTRL_STYPE: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        range_ok     = sign_run_ok(imm, 11);
      end
      EXT_CTRL_BTYPE: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        range_ok     = sign_run_ok(imm, 12);
        align_ok     = ~imm[0];
      end
      EXT_CTRL_UTYPE: begin
        instr[31:12] = imm[31:12];
        align_ok     = (imm[11:0] == 12'd0);
      end
      EXT_CTRL_JTYPE: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        range_ok     = sign_run_ok(imm, 20);
        align_ok     = ~imm[0];
      end
      default: begin
        // Zero or multi-hot select: leave the base word untouched.
        instr  = base;
        op_bad = 1'b1;
      end
    endcase

    if (op_bad)         err = ERR_OP;
    else if (!align_ok) err = ERR_ALIGN;
    else if (!range_ok) err = ERR_RANGE;
    else                err = ERR_OK;
  end

endmodule

// File: rtl/imm_encoder_480.sv
// Two-stage immediate encoder feeding the instruction-memory write port; IMM_ENC_STATS_EN adds OK/error counters.
// Latency 2 cycles accept-to-out_valid, 1 beat/cycle; out_ready low holds the output, S1 fills, then in_ready drops.
module imm_encoder_480
  import imm_encoder_480_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_extop,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [1:0]        out_err
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_ok,
  output logic [CNT_W-1:0]  cnt_err
`endif
);

  s1_t              s1_q;
  logic             s1_valid;
  logic [DATA_W-1:0] pk_instr;
  logic [1:0]       pk_err;
  logic             s1_accept;
  logic             s2_load;

  assign in_ready  = !s1_valid || !out_valid || out_ready;
  assign s1_accept = in_valid && in_ready;
  assign s2_load   = s1_valid && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_accept) begin
      s1_valid   <= 1'b1;
      s1_q.extop <= in_extop;
      s1_q.imm   <= in_imm;
      s1_q.base  <= in_base;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  imm_pack_480 #(.DATA_W(DATA_W)) u_pack (
    .extop (s1_q.extop),
    .imm   (s1_q.imm),
    .base  (s1_q.base),
    .instr (pk_instr),
    .err   (pk_err)
  );

  // Output register only changes on load, so it is stable for the whole stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= ERR_OK;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_instr <= pk_instr;
      out_err   <= pk_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IMM_ENC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic out_hs;

  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (out_hs) begin
      if (out_err == ERR_OK) begin
        if (cnt_ok != CNT_MAX) cnt_ok <= cnt_ok + 1'b1;
      end else begin
        if (cnt_err != CNT_MAX) cnt_err <= cnt_err + 1'b1;
      end
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_imm_encoder_480.sv
// Scoreboarded random/directed bench for imm_encoder_480; reference packs fields from a bit-position table.
module tb_imm_encoder_480;
  import imm_encoder_480_pkg::*;

`ifdef IMM_ENC_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_extop = '0;
  logic [31:0] in_imm = '0;
  logic [31:0] in_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;
`endif

  exp_t        sc_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          or_mode = 1;
  int          beat_no = 0;
  longint      m_ok = 0;
  longint      m_err = 0;
  logic        stalled = 1'b0;
  logic [31:0] prev_instr;
  logic [1:0]  prev_err;

  imm_encoder_480 #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_extop  (in_extop),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
`ifdef IMM_ENC_STATS_EN
    ,
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  // Which immediate bit lands in instruction bit k for format fmt (-1: base passes through).
  function automatic int src_bit(input int fmt, input int k);
    case (fmt)
      0: return (k >= 20 && k <= 24) ? k - 20 : -1;
      1: return (k >= 20) ? k - 20 : -1;
      2: return (k >= 25) ? k - 20 : ((k >= 7 && k <= 11) ? k - 7 : -1);
      3: begin
        if (k == 31) return 12;
        if (k >= 25 && k <= 30) return k - 20;
        if (k >= 8 && k <= 11) return k - 7;
        if (k == 7) return 11;
        return -1;
      end
      4: return (k >= 12) ? k : -1;
      5: begin
        if (k == 31) return 20;
        if (k >= 21 && k <= 30) return k - 20;
        if (k == 20) return 11;
        if (k >= 12 && k <= 19) return k;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic exp_t model(input logic [5:0] e, input logic [31:0] imm, input logic [31:0] base);
    exp_t   r;
    int     fmt;
    int     sb;
    longint s;
    bit     rng_ok;
    bit     al_ok;
    s = longint'($signed(imm));
    fmt = -1;
    case (e)
      6'b100000: fmt = 0;
      6'b010000: fmt = 1;
      6'b001000: fmt = 2;
      6'b000100: fmt = 3;
      6'b000010: fmt = 4;
      6'b000001: fmt = 5;
      default:   fmt = -1;
    endcase
    r.instr = base;
    r.err   = 2'b00;
    if (fmt < 0) begin
      r.err = 2'b11;
      return r;
    end
    for (int k = 0; k < 32; k++) begin
      sb = src_bit(fmt, k);
      if (sb >= 0) r.instr[k] = imm[sb];
    end
    case (fmt)
      0:       rng_ok = (imm < 32);
      1, 2:    rng_ok = (s >= -2048 && s <= 2047);
      3:       rng_ok = (s >= -4096 && s <= 4095);
      5:       rng_ok = (s >= -(64'sd1 <<< 20) && s < (64'sd1 <<< 20));
      default: rng_ok = 1'b1;
    endcase
    case (fmt)
      3, 5:    al_ok = (imm % 2 == 0);
      4:       al_ok = (imm % 4096 == 0);
      default: al_ok = 1'b1;
    endcase
    if (!al_ok)       r.err = 2'b10;
    else if (!rng_ok) r.err = 2'b01;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = ($urandom_range(3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: a handshake seen at a falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        tests++;
        if (out_instr !== prev_instr || out_err !== prev_err) begin
          fails++;
          $display("FAIL hold_stable: got %h/%b, held value %h/%b", out_instr, out_err, prev_instr, prev_err);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (sc_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h/%b, no beat outstanding", out_instr, out_err);
        end else begin
          mon_e = sc_q.pop_front();
          if (out_instr !== mon_e.instr || out_err !== mon_e.err) begin
            fails++;
            $display("FAIL beat_data #%0d: got %h/%b, exp %h/%b", beat_no, out_instr, out_err, mon_e.instr, mon_e.err);
          end
          if (mon_e.err == 2'b00) begin
            if (m_ok < (64'd1 << CNT_W) - 1) m_ok++;
          end else begin
            if (m_err < (64'd1 << CNT_W) - 1) m_err++;
          end
        end
        beat_no++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled    = 1'b1;
        prev_instr = out_instr;
        prev_err   = out_err;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send(input logic [5:0] e, input logic [31:0] imm, input logic [31:0] base);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_extop = e;
    in_imm   = imm;
    in_base  = base;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sc_q.push_back(model(e, imm, base));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sc_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sc_q.size());
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, exp %b", name, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  e;
    logic [31:0] imm;
    int          r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset_out_valid", out_valid, 1'b0);
    tests++;
    if (out_instr !== 32'h0 || out_err !== 2'b00) begin
      fails++;
      $display("FAIL reset_out_word: got %h/%b, exp 00000000/00", out_instr, out_err);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    check1("reset_in_ready", in_ready, 1'b1);

    // Directed beats, output always ready.
    send(EXT_CTRL_ITYPE, 32'hFFFF_FFFF, 32'h0000_0013);
    send(EXT_CTRL_UTYPE, 32'h1234_5000, 32'h0000_0037);
    send(EXT_CTRL_UTYPE, 32'h1234_5001, 32'h0000_0037);
    send(EXT_CTRL_BTYPE, 32'h0000_0800, 32'h0000_0063);
    send(EXT_CTRL_JTYPE, 32'h0000_0003, 32'h0000_006F);
    send(EXT_CTRL_ITYPE_SHAMT, 32'd32, 32'h0000_1013);
    send(6'b000011, 32'h0000_0004, 32'hDEAD_BEEF);
    send(6'b000000, 32'h0000_0004, 32'h1234_5678);
    send(EXT_CTRL_STYPE, 32'hFFFF_F800, 32'h0000_0023);
    send(EXT_CTRL_STYPE, 32'h0000_0800, 32'h0000_0023);
    send(EXT_CTRL_JTYPE, 32'hFFF0_0000, 32'h0000_006F);
    send(EXT_CTRL_BTYPE, 32'h0000_1000, 32'h0000_0063);
    wait_drain();

    // Backpressure: four back-to-back beats against a stalled output.
    or_mode = 2;
    @(posedge clk);
    #2;
    send(EXT_CTRL_ITYPE, 32'h0000_0123, 32'h0000_0093);
    send(EXT_CTRL_STYPE, 32'h0000_0456, 32'h0000_2023);
    #1;
    check1("in_ready_after_2nd_accept", in_ready, 1'b0);
    fork
      begin
        send(EXT_CTRL_UTYPE, 32'hABCD_E000, 32'h0000_00B7);
        send(EXT_CTRL_JTYPE, 32'h0000_0FFE, 32'h0000_00EF);
      end
      begin
        repeat (3) @(posedge clk);
        or_mode = 1;
      end
    join
    wait_drain();

    // Reset with two beats in flight.
    or_mode = 2;
    @(posedge clk);
    #2;
    send(EXT_CTRL_ITYPE, 32'h0000_0001, 32'h0000_0013);
    send(EXT_CTRL_ITYPE, 32'h0000_0002, 32'h0000_0013);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sc_q.delete();
    m_ok  = 0;
    m_err = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check1("rst_out_valid_cleared", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    or_mode = 1;
    @(posedge clk);
    #2;
    send(EXT_CTRL_BTYPE, 32'hFFFF_FFF0, 32'h0000_0063);
    check1("latency_not_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("latency_valid", out_valid, 1'b1);
    wait_drain();

    // Randomised traffic with random output stalls.
    or_mode = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(8);
      if (r < 6)       e = 6'b000001 << r;
      else if (r == 6) e = 6'($urandom_range(63));
      else             e = 6'b000001 << $urandom_range(5);
      case ($urandom_range(4))
        0:       imm = 32'($urandom_range(8191)) - 32'd4096;
        1:       imm = $urandom & 32'hFFFF_F000;
        2:       imm = 32'($urandom_range(63));
        3:       imm = 32'($urandom_range(2097151)) - 32'd1048576;
        default: imm = $urandom;
      endcase
      send(e, imm, $urandom);
    end
    or_mode = 1;
    wait_drain();

`ifdef IMM_ENC_STATS_EN
    repeat (2) @(negedge clk);
    tests++;
    if (longint'(cnt_ok) != m_ok) begin
      fails++;
      $display("FAIL cnt_ok: got %0d, exp %0d", cnt_ok, m_ok);
    end
    tests++;
    if (longint'(cnt_err) != m_err) begin
      fails++;
      $display("FAIL cnt_err: got %0d, exp %0d", cnt_err, m_err);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
